// File: rtl/sram_bist_pkg.sv
// ============================================================================
// Module  : sram_bist_pkg
// Brief   : Shared state encoding, sweep directions and pattern select for the BIST.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR0   = 3'd1,
        ST_RD0   = 3'd2,
        ST_WR1   = 3'd3,
        ST_RD1   = 3'd4,
        ST_FLUSH = 3'd5,
        ST_DONE  = 3'd6
    } bist_state_e;

    localparam logic c_DIR_UP   = 1'b0;
    localparam logic c_DIR_DOWN = 1'b1;

    typedef enum logic {
        PAT_TRUE = 1'b0,
        PAT_INV  = 1'b1
    } pat_sel_e;

    // The second half of the march runs downwards with the inverted background.
    function automatic logic phase_dir(input bist_state_e s);
        return ((s == ST_WR1) || (s == ST_RD1)) ? c_DIR_DOWN : c_DIR_UP;
    endfunction

    function automatic pat_sel_e phase_pat(input bist_state_e s);
        return ((s == ST_WR1) || (s == ST_RD1)) ? PAT_INV : PAT_TRUE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_bist_cmp.sv
// ============================================================================
// Module  : sram_bist_cmp
// Brief   : Delayed read-data compare with saturating error count and first-fail address.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_bist_cmp
    import sram_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int ERR_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  discard_i,
    input  logic                  rd_issue_i,
    input  logic [DATA_WIDTH-1:0] rd_exp_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [ERR_W-1:0]      err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

    localparam logic [ERR_W-1:0] c_ERR_MAX = '1;

    logic                  pend_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ERR_W-1:0]      err_q;
    logic [ERR_W-1:0]      err_d;
    logic [ADDR_WIDTH-1:0] first_q;
    logic [ADDR_WIDTH-1:0] first_d;
    logic                  w_miscmp;

    assign w_miscmp = pend_q && !discard_i && (rdata_i != exp_q);

    // The counter never wraps, so a zero count marks the first miscompare of a run.
    always_comb begin
        err_d   = err_q;
        first_d = first_q;
        if (clear_i) begin
            err_d   = '0;
            first_d = '0;
        end else if (w_miscmp) begin
            if (err_q != c_ERR_MAX) begin
                err_d = err_q + ERR_W'(1);
            end
            if (err_q == '0) begin
                first_d = addr_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q  <= 1'b0;
            exp_q   <= '0;
            addr_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            pend_q  <= rd_issue_i && !discard_i;
            exp_q   <= rd_exp_i;
            addr_q  <= rd_addr_i;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign err_count_o      = err_q;
    assign first_err_addr_o = first_q;

endmodule

`default_nettype wire

// File: rtl/sram_bist_ctrl.sv
// ============================================================================
// Module  : sram_bist_ctrl
// Brief   : Fixed-latency march BIST (WR0/RD0/WR1/RD1) driving a one-cycle-latency SRAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    parameter  int NUM_WORDS  = 1024,
    parameter  int ERR_W      = 16,
    localparam int ADDR_WIDTH = $clog2(NUM_WORDS),
    localparam int BE_WIDTH   = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [DATA_WIDTH-1:0] pattern_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ERR_W-1:0]      err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [BE_WIDTH-1:0]   c_BE_ALL    = '1;

    bist_state_e           state_q;
    logic [DATA_WIDTH-1:0] pat_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  req_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_WIDTH-1:0]   be_q;

    logic                  w_idle_like;
    logic                  w_accept;
    logic                  w_dir;
    logic                  w_phase_end;
    logic [ADDR_WIDTH-1:0] w_addr_step;
    logic [DATA_WIDTH-1:0] w_exp;

    assign w_idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign w_accept    = w_idle_like && start_i && !abort_i;
    assign w_dir       = phase_dir(state_q);
    assign w_phase_end = (addr_q == ((w_dir == c_DIR_UP) ? c_LAST_ADDR : '0));
    assign w_addr_step = (w_dir == c_DIR_UP) ? addr_q + ADDR_WIDTH'(1) : addr_q - ADDR_WIDTH'(1);
    assign w_exp       = (phase_pat(state_q) == PAT_TRUE) ? pat_q : ~pat_q;

    // Phase hand-over reloads the address in the same edge as the last access,
    // so the request stays continuous across all four sweeps.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (abort_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q <= ST_WR0;
                        pat_q   <= pattern_i;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= '0;
                        wdata_q <= pattern_i;
                        be_q    <= c_BE_ALL;
                    end
                end
                ST_WR0: begin
                    if (w_phase_end) begin
                        state_q <= ST_RD0;
                        we_q    <= 1'b0;
                        addr_q  <= '0;
                    end else begin
                        addr_q  <= w_addr_step;
                    end
                end
                ST_RD0: begin
                    if (w_phase_end) begin
                        state_q <= ST_WR1;
                        we_q    <= 1'b1;
                        addr_q  <= c_LAST_ADDR;
                        wdata_q <= ~pat_q;
                    end else begin
                        addr_q  <= w_addr_step;
                    end
                end
                ST_WR1: begin
                    if (w_phase_end) begin
                        state_q <= ST_RD1;
                        we_q    <= 1'b0;
                        addr_q  <= c_LAST_ADDR;
                    end else begin
                        addr_q  <= w_addr_step;
                    end
                end
                ST_RD1: begin
                    if (w_phase_end) begin
                        state_q <= ST_FLUSH;
                        req_q   <= 1'b0;
                        be_q    <= '0;
                    end else begin
                        addr_q  <= w_addr_step;
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    be_q    <= '0;
                end
            endcase
        end
    end

    sram_bist_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ERR_W      (ERR_W)
    ) u_cmp (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .clear_i          (w_accept),
        .discard_i        (abort_i),
        .rd_issue_i       (req_q && !we_q),
        .rd_exp_i         (w_exp),
        .rd_addr_i        (addr_q),
        .rdata_i          (mem_rdata_i),
        .err_count_o      (err_count_o),
        .first_err_addr_o (first_err_addr_o)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = done_q && (err_count_o == '0);
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_bist_ctrl.sv
// ============================================================================
// Module  : tb_sram_bist_ctrl
// Brief   : Scoreboard bench for sram_bist_ctrl with a fault-injecting SRAM model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_bist_ctrl;

    localparam int DW = 32;
    localparam int N  = 16;
    localparam int AW = 4;
    localparam int BW = 4;

    typedef struct {
        int          cyc;
        bit          we;
        int          addr;
        logic [DW-1:0] wd;
        int          err;
    } acc_t;

    typedef struct {
        int done_cyc;
        bit pass;
        int err_a;
        int first_a;
        int err_b;
        int first_b;
    } run_t;

    logic          clk       = 1'b0;
    logic          rst_i     = 1'b1;
    logic          start_i   = 1'b0;
    logic          abort_i   = 1'b0;
    logic [DW-1:0] pattern_i = '0;

    logic          busy_o, done_o, pass_o;
    logic [15:0]   err_count_o;
    logic [AW-1:0] first_err_addr_o;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [BW-1:0] mem_be_o;
    logic [DW-1:0] rdata_a;

    logic          b_busy, b_done, b_pass;
    logic [0:0]    b_err;
    logic [AW-1:0] b_first;
    logic          b_req, b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [BW-1:0] b_be;
    logic [DW-1:0] rdata_b;

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;
    int start_cyc = 0;
    int corrupt_cyc = -1;
    int stuck_addr = -1;
    logic [DW-1:0] stuck_mask = '0;
    int flip0 = -1;
    int flip1 = -1;

    logic [DW-1:0] smem [0:N-1];
    acc_t acc_q[$];
    run_t run_q[$];

    always #5 clk = ~clk;

    sram_bist_ctrl #(.DATA_WIDTH(DW), .NUM_WORDS(N), .ERR_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i), .pattern_i(pattern_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_count_o(err_count_o),
        .first_err_addr_o(first_err_addr_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rdata_i(rdata_a)
    );

    sram_bist_ctrl #(.DATA_WIDTH(DW), .NUM_WORDS(N), .ERR_W(1)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i), .pattern_i(pattern_i),
        .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass), .err_count_o(b_err),
        .first_err_addr_o(b_first), .mem_req_o(b_req), .mem_we_o(b_we),
        .mem_addr_o(b_addr), .mem_wdata_o(b_wdata), .mem_be_o(b_be),
        .mem_rdata_i(rdata_b)
    );

    function automatic logic [DW-1:0] sram_rd(input int a, input int rel);
        logic [DW-1:0] d;
        d = smem[a];
        if (a == stuck_addr) d = d | stuck_mask;
        if (a == flip0 || a == flip1) d = d ^ 32'h0000_0100;
        if (rel == corrupt_cyc) d = d ^ 32'h8000_0000;
        return d;
    endfunction

    // SRAM model: one-cycle read latency; only the full-width DUT writes the array.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (mem_req_o && mem_we_o) smem[mem_addr_o] <= mem_wdata_o;
        if (mem_req_o && !mem_we_o) rdata_a <= sram_rd(int'(mem_addr_o), cyc_cnt - start_cyc + 1);
        if (b_req && !b_we) rdata_b <= sram_rd(int'(b_addr), cyc_cnt - start_cyc + 1);
    end

    function automatic void chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void push_accesses(input logic [DW-1:0] p, input int last_k,
                                          input int ek1, input int ev1,
                                          input int ek2, input int ev2);
        for (int k = 1; k <= 4 * N && k <= last_k; k++) begin
            acc_t e;
            int ph;
            int ix;
            ph     = (k - 1) / N;
            ix     = (k - 1) % N;
            e.cyc  = k;
            e.we   = (ph == 0 || ph == 2);
            e.addr = (ph < 2) ? ix : N - 1 - ix;
            e.wd   = (ph == 0) ? p : ~p;
            e.err  = (k == ek1) ? ev1 : ((k == ek2) ? ev2 : -1);
            acc_q.push_back(e);
        end
    endfunction

    function automatic void push_run(input bit pass, input int ea, input int fa,
                                     input int eb, input int fb);
        run_t r;
        r.done_cyc = 4 * N + 2;
        r.pass     = pass;
        r.err_a    = ea;
        r.first_a  = fa;
        r.err_b    = eb;
        r.first_b  = fb;
        run_q.push_back(r);
    endfunction

    task automatic start_run(input logic [DW-1:0] p);
        @(negedge clk);
        pattern_i = p;
        start_i   = 1'b1;
        start_cyc = cyc_cnt + 1;
        @(negedge clk);
        start_i   = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, done_o, 1);
        @(negedge clk);
    endtask

    // Monitor: pops one expected access per requesting cycle and one run result per done rise.
    initial begin : monitor
        bit   done_prev;
        int   rel;
        acc_t e;
        run_t r;
        done_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rel = cyc_cnt - start_cyc + 1;
            if (mem_req_o) begin
                if (acc_q.size() == 0) begin
                    chk("acc_q_size", acc_q.size(), 1);
                end else begin
                    e = acc_q.pop_front();
                    chk("acc_cycle", rel, e.cyc);
                    chk("acc_we", mem_we_o, e.we);
                    chk("acc_addr", mem_addr_o, e.addr);
                    if (e.we) chk("acc_wdata", mem_wdata_o, e.wd);
                    chk("acc_be", mem_be_o, 4'hF);
                    if (e.err >= 0) chk("err_at_cycle", err_count_o, e.err);
                end
            end
            if (done_o && !done_prev) begin
                if (run_q.size() == 0) begin
                    chk("run_q_size", run_q.size(), 1);
                end else begin
                    r = run_q.pop_front();
                    chk("done_cycle", rel, r.done_cyc);
                    chk("pass", pass_o, r.pass);
                    chk("err_count", err_count_o, r.err_a);
                    chk("first_err_addr", first_err_addr_o, r.first_a);
                    chk("err_count_b", b_err, r.err_b);
                    chk("first_err_addr_b", b_first, r.first_b);
                    chk("pass_b", b_pass, r.err_b == 0);
                end
            end
            done_prev = done_o;
        end
    end

    initial begin : stim
        logic [DW-1:0] p;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {busy_o, done_o, pass_o, err_count_o, first_err_addr_o}, 0);
        chk("rst_mem", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, 0);
        rst_i = 1'b0;
        @(negedge clk);

        p = 32'hA5A5_A5A5;
        push_accesses(p, 4 * N, -1, 0, -1, 0);
        push_run(1'b1, 0, 0, 0, 0);
        start_run(p);
        wait_done("done_clean");

        stuck_addr = 5;
        stuck_mask = 32'h0000_0008;
        p = 32'h0000_0000;
        push_accesses(p, 4 * N, -1, 0, -1, 0);
        push_run(1'b0, 1, 5, 1, 5);
        start_run(p);
        wait_done("done_stuck");
        stuck_addr = -1;

        flip0 = 2;
        flip1 = 9;
        p = 32'h0F0F_3C3C;
        push_accesses(p, 4 * N, -1, 0, -1, 0);
        push_run(1'b0, 4, 2, 1, 2);
        start_run(p);
        wait_done("done_multi");
        flip0 = -1;
        flip1 = -1;

        // Corrupt only the RD0 read of the last word; its compare lands in WR1's first cycle.
        corrupt_cyc = 2 * N;
        p = 32'h1234_5678;
        push_accesses(p, 4 * N, 2 * N + 1, 0, 2 * N + 2, 1);
        push_run(1'b0, 1, N - 1, 1, N - 1);
        start_run(p);
        wait_done("done_boundary");
        corrupt_cyc = -1;

        chk("done_held", done_o, 1);
        @(negedge clk);
        pattern_i = 32'hDEAD_BEEF;
        start_i   = 1'b1;
        abort_i   = 1'b1;
        @(negedge clk);
        start_i   = 1'b0;
        abort_i   = 1'b0;
        chk("prio_done", done_o, 0);
        chk("prio_busy", busy_o, 0);
        repeat (3) @(negedge clk);

        p = 32'hC3C3_C3C3;
        push_accesses(p, 20, -1, 0, -1, 0);
        start_run(p);
        repeat (4) @(negedge clk);
        pattern_i = ~p;
        start_i   = 1'b1;
        repeat (15) @(negedge clk);
        abort_i   = 1'b1;
        @(negedge clk);
        abort_i   = 1'b0;
        start_i   = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_req", mem_req_o, 0);
        chk("abort_done", done_o, 0);
        repeat (5) @(negedge clk);
        chk("abort_done_later", done_o, 0);

        p = 32'h5A5A_00FF;
        push_accesses(p, 55, -1, 0, -1, 0);
        start_run(p);
        repeat (54) @(negedge clk);
        rst_i = 1'b1;
        #1;
        chk("midrst_ctrl", {busy_o, done_o, pass_o, err_count_o, first_err_addr_o}, 0);
        chk("midrst_mem", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        chk("midrst_acc_drained", acc_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("midrst_idle_req", mem_req_o, 0);

        p = 32'hFFFF_0000;
        push_accesses(p, 4 * N, -1, 0, -1, 0);
        push_run(1'b1, 0, 0, 0, 0);
        start_run(p);
        wait_done("done_after_rst");

        repeat (3) @(negedge clk);
        chk("acc_q_left", acc_q.size(), 0);
        chk("run_q_left", run_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/sram_bist_ctrl.md
SRAM_BIST_CTRL -- requirements
Module: sram_bist_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: SRAM word width in bits.
REQ-002 SHALL have parameter NUM_WORDS, default 1024: SRAM depth, at least 2.
REQ-003 SHALL have parameter ERR_W, default 16: error counter width.
REQ-004 SHALL derive localparam ADDR_WIDTH = $clog2(NUM_WORDS) and BE_WIDTH = (DATA_WIDTH+7)/8.
REQ-005 SHALL have one clock and an asynchronous active-high reset.
REQ-006 SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have port start_i, input, 1 bit: start pulse, sampled in IDLE or DONE.
REQ-009 SHALL have port abort_i, input, 1 bit: abort the test, return to IDLE.
REQ-010 SHALL have port pattern_i, input, DATA_WIDTH bits: background pattern P, latched at start.
REQ-011 SHALL have port busy_o, output, 1 bit: test in progress.
REQ-012 SHALL have port done_o, output, 1 bit: level, test complete.
REQ-013 SHALL have port pass_o, output, 1 bit: valid while done_o is high; high when err_count_o == 0.
REQ-014 SHALL have port err_count_o, output, ERR_W bits: saturating miscompare count.
REQ-015 SHALL have port first_err_addr_o, output, ADDR_WIDTH bits: address of the first miscompare.
REQ-016 SHALL have port mem_req_o, output, 1 bit: SRAM request.
REQ-017 SHALL have port mem_we_o, output, 1 bit: SRAM write enable.
REQ-018 SHALL have port mem_addr_o, output, ADDR_WIDTH bits: SRAM word address.
REQ-019 SHALL have port mem_wdata_o, output, DATA_WIDTH bits: SRAM write data.
REQ-020 SHALL have port mem_be_o, output, BE_WIDTH bits: byte enables, all ones whenever mem_req_o is high.
REQ-021 SHALL have port mem_rdata_i, input, DATA_WIDTH bits: SRAM read data, valid one cycle after a read request.

Function
REQ-022 SHALL implement states IDLE, WR0, RD0, WR1, RD1, FLUSH and DONE.
REQ-023 SHALL, on start_i in IDLE or DONE, latch P, clear the error count, clear first_err_addr_o, and enter WR0 the next cycle.
REQ-024 SHALL, in WR0, write P to addresses 0..NUM_WORDS-1 ascending, one per cycle.
REQ-025 SHALL, in RD0, read addresses 0..NUM_WORDS-1 ascending and expect P.
REQ-026 SHALL, in WR1, write ~P to addresses NUM_WORDS-1..0 descending.
REQ-027 SHALL, in RD1, read addresses NUM_WORDS-1..0 descending and expect ~P.
REQ-028 SHALL, in FLUSH (one cycle), perform the final compare, then enter DONE.
REQ-029 SHALL move to the next phase directly after the last address of a phase, with no idle cycle between phases.
REQ-030 SHALL keep mem_req_o high for exactly 4*NUM_WORDS consecutive cycles.
REQ-031 SHALL set mem_we_o = 1 only in WR0 and WR1.
REQ-032 SHALL drive mem_req_o low in IDLE, FLUSH and DONE.
REQ-033 SHALL derive all mem_* outputs from registers only, with no combinational path from any input.
REQ-034 SHALL complete a run in fixed time: start accepted at cycle 0, WR0 spans cycles 1..N, FLUSH is at cycle 4N+1, and done_o rises at cycle 4N+2.
REQ-035 SHALL perform each compare in the cycle after its read request, using a registered read-pending flag, expected data and address.
REQ-036 SHALL allow the compare of the last RD0 read to overlap the first WR1 cycle.
REQ-037 SHALL, on a miscompare, increment err_count_o, saturating at 2^ERR_W-1.
REQ-038 SHALL capture first_err_addr_o only on the first miscompare of a run.
REQ-039 SHALL ignore start_i while busy_o is high.
REQ-040 SHALL, on abort_i in any busy state, enter IDLE the next cycle, with mem_req_o low and the pending compare discarded.
REQ-041 SHALL give abort_i priority over start_i when both are asserted in the same cycle.
REQ-042 SHALL hold busy_o high in WR0..FLUSH, and hold done_o high in DONE until the next start_i or abort_i.

Reset
REQ-043 SHALL, while rst_i is high, asynchronously force state IDLE.
REQ-044 SHALL, while rst_i is high, force all of busy_o, done_o, pass_o, err_count_o, first_err_addr_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o and the read-pending flag to 0.
REQ-045 SHALL, when rst_i is asserted mid-run, drop mem_req_o immediately and make no further SRAM access until a new start_i.

Structure
REQ-046 SHALL place the state enum, the phase-direction constants and the pattern-select typedef in shared package sram_bist_pkg.
REQ-047 SHALL implement compare, error counting and first-address capture in sub-module sram_bist_cmp.
REQ-048 SHALL size the RTL at 150-300 lines in total.

Verification
REQ-049 SHALL test a clean run: N=16, P=0xA5A5..., fault-free sp_sram -> mem_req_o high cycles 1..64, done_o at cycle 66, pass_o=1, err_count_o=0.
REQ-050 SHALL test a stuck bit: bit 3 stuck-at-1 at address 5 with P=0 -> err_count_o=1, first_err_addr_o=5, pass_o=0.
REQ-051 SHALL test multiple faults: faulty words at addresses 2 and 9 with ERR_W=1 -> err_count_o saturates at 1, first_err_addr_o=2.
REQ-052 SHALL test abort: abort_i at cycle 20 -> state IDLE, mem_req_o=0 from cycle 21, done_o stays 0, and start_i ignored at cycles 5-19.
REQ-053 SHALL test reset mid-run: rst_i pulse during RD1 -> all outputs 0 immediately; a new start_i gives a full clean run with done_o 4N+2 cycles later.
REQ-054 SHALL test the phase boundary: a corrupt read at address N-1 in RD0 -> error counted during WR1 cycle 1; the address sequence is 15..0 in WR1.
